// File: rtl/ostar_accum_pkg.sv
// Shared definitions for the O* row accumulator: Q9.17 element format,
// default vector geometry, and the accumulator FSM state encoding.
package ostar_accum_pkg;

    localparam int MAX_EMBEDDING_DIM = 4;
    localparam int MAX_SEQ_LEN       = 8;

    // Embedding lanes plus the augmented row-sum lane.
    localparam int OSTAR_DIM         = MAX_EMBEDDING_DIM + 1;

    // Signed Q9.17 element.
    localparam int Q_ELEM_W          = 27;
    localparam int FRAC              = 17;

    localparam logic [Q_ELEM_W-1:0] Q_MAX = {1'b0, {(Q_ELEM_W-1){1'b1}}};
    localparam logic [Q_ELEM_W-1:0] Q_MIN = {1'b1, {(Q_ELEM_W-1){1'b0}}};

    typedef logic [OSTAR_DIM-1:0][Q_ELEM_W-1:0] star_vector_t;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } ostar_state_e;

endpackage

// File: rtl/ostar_accum_lane_add.sv
// One accumulator lane: signed Q9.17 + Q9.17 with clamping to the Q9.17
// range and an overflow flag whenever the clamp engages.
module ostar_lane_add
    import ostar_accum_pkg::*;
(
    input  logic [Q_ELEM_W-1:0] a_i,
    input  logic [Q_ELEM_W-1:0] b_i,
    output logic [Q_ELEM_W-1:0] sum_o,
    output logic                ovf_o
);

    logic [Q_ELEM_W:0] wide_s;

    // Add with one guard bit; disagreeing top bits mean the true sum left the range.
    always_comb begin
        wide_s = {a_i[Q_ELEM_W-1], a_i} + {b_i[Q_ELEM_W-1], b_i};
        ovf_o  = (wide_s[Q_ELEM_W] != wide_s[Q_ELEM_W-1]);
        if (ovf_o) begin
            if (wide_s[Q_ELEM_W]) begin
                sum_o = Q_MIN;
            end else begin
                sum_o = Q_MAX;
            end
        end else begin
            sum_o = wide_s[Q_ELEM_W-1:0];
        end
    end

endmodule

// File: rtl/ostar_accum.sv
// O* row accumulator: takes one (exp_o, exp_v) pair per key from expmul,
// stores their saturated lane-wise sum as the committed O*, feeds it back to
// expmul, and hands the finished row downstream on the row's last key.
module ostar_accum
    import ostar_accum_pkg::*;
#(
    parameter  int DIM      = OSTAR_DIM,
    parameter  int MAX_KEYS = MAX_SEQ_LEN,
    localparam int CNT_W    = $clog2(MAX_KEYS + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             vld_in,
    output logic                             rdy_out,
    input  logic [DIM-1:0][Q_ELEM_W-1:0]     exp_o_in,
    input  logic [DIM-1:0][Q_ELEM_W-1:0]     exp_v_in,
    input  logic                             last_in,
    input  logic                             issue_in,
    output logic [DIM-1:0][Q_ELEM_W-1:0]     o_star_prev_out,
    output logic                             o_star_prev_vld,
    output logic                             vld_out,
    input  logic                             rdy_in,
    output logic [DIM-1:0][Q_ELEM_W-1:0]     o_star_out,
    output logic [CNT_W-1:0]                 key_cnt_out,
    output logic                             err_out
);

    ostar_state_e                 state_q, state_d;
    logic                         inflight_q, inflight_d;
    logic                         err_q, err_d;
    logic [DIM-1:0][Q_ELEM_W-1:0] acc_q, acc_d;
    logic [DIM-1:0][Q_ELEM_W-1:0] ostar_q, ostar_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [CNT_W-1:0]             cnt_out_q, cnt_out_d;

    logic [DIM-1:0][Q_ELEM_W-1:0] sum_s;
    logic [DIM-1:0]               ovf_s;
    logic                         accept_s;
    logic                         drain_s;
    logic                         issue_bad_s;
    logic                         issue_ok_s;
    logic                         cnt_full_s;
    logic [CNT_W-1:0]             cnt_inc_s;

    genvar g;
    generate
        for (g = 0; g < DIM; g++) begin : g_lane
            ostar_lane_add u_lane (
                .a_i   (exp_o_in[g]),
                .b_i   (exp_v_in[g]),
                .sum_o (sum_s[g]),
                .ovf_o (ovf_s[g])
            );
        end
    endgenerate

    assign accept_s    = vld_in && (state_q == ACCUM);
    assign drain_s     = rdy_in && (state_q == DRAIN);
    // A second issue before the result returns, or any issue while draining, is dropped.
    assign issue_bad_s = issue_in && (inflight_q || (state_q == DRAIN));
    assign issue_ok_s  = issue_in && !issue_bad_s;
    assign cnt_full_s  = (cnt_q == CNT_W'(MAX_KEYS));
    assign cnt_inc_s   = cnt_full_s ? cnt_q : (cnt_q + CNT_W'(1));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: last key moves to DRAIN; downstream handshake returns to ACCUM (no bypass).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM: begin
                if (accept_s && last_in) begin
                    state_d = DRAIN;
                end else begin
                    state_d = ACCUM;
                end
            end
            DRAIN: begin
                if (rdy_in) begin
                    state_d = ACCUM;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // Handshake outputs decoded straight from registered state.
    always_comb begin
        rdy_out         = (state_q == ACCUM);
        vld_out         = (state_q == DRAIN);
        o_star_prev_vld = (state_q == ACCUM) && !inflight_q;
    end

    // Datapath next-state: accumulator, key counter, in-flight tracking, sticky error.
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ostar_d   = ostar_q;
        cnt_out_d = cnt_out_q;
        if (accept_s) begin
            acc_d = sum_s;
            cnt_d = cnt_inc_s;
            if (last_in) begin
                ostar_d   = sum_s;
                cnt_out_d = cnt_inc_s;
            end else begin
                ostar_d   = ostar_q;
                cnt_out_d = cnt_out_q;
            end
        end else if (drain_s) begin
            acc_d = '0;
            cnt_d = '0;
        end else begin
            acc_d = acc_q;
            cnt_d = cnt_q;
        end

        // A legal issue in the same cycle as an accept starts the next key.
        if (issue_ok_s) begin
            inflight_d = 1'b1;
        end else if (accept_s || drain_s) begin
            inflight_d = 1'b0;
        end else begin
            inflight_d = inflight_q;
        end

        err_d = err_q | issue_bad_s |
                (accept_s && (!inflight_q || (|ovf_s) || cnt_full_s));
    end

    // Datapath and output registers; reset discards any partial row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q      <= '0;
            ostar_q    <= '0;
            cnt_q      <= '0;
            cnt_out_q  <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            ostar_q    <= ostar_d;
            cnt_q      <= cnt_d;
            cnt_out_q  <= cnt_out_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    assign o_star_prev_out = acc_q;
    assign o_star_out      = ostar_q;
    assign key_cnt_out     = cnt_out_q;
    assign err_out         = err_q;

endmodule

// File: tb/tb_ostar_accum.sv
// Self-checking bench for ostar_accum: directed scenarios followed by
// randomized rows, all compared against a transaction-level reference model.
module tb_ostar_accum;
    import ostar_accum_pkg::*;

    localparam int     DIM      = OSTAR_DIM;
    localparam int     MAX_KEYS = MAX_SEQ_LEN;
    localparam int     CNT_W    = $clog2(MAX_KEYS + 1);
    localparam longint QMAX     = 64'sd67108863;
    localparam longint QMIN     = -64'sd67108864;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         vld_in = 1'b0;
    logic         last_in = 1'b0;
    logic         issue_in = 1'b0;
    logic         rdy_in = 1'b0;
    star_vector_t exp_o = '0;
    star_vector_t exp_v = '0;
    logic         rdy_out, o_star_prev_vld, vld_out, err_out;
    star_vector_t o_star_prev_out, o_star_out;
    logic [CNT_W-1:0] key_cnt_out;

    int checks   = 0;
    int failures = 0;

    // Reference model state: the row as the specification describes it.
    longint m_acc [DIM];
    longint m_out [DIM];
    int     m_cnt, m_cnt_out;
    bit     m_inflight, m_err, m_drain;

    ostar_accum dut (
        .clk             (clk),
        .rst             (rst),
        .vld_in          (vld_in),
        .rdy_out         (rdy_out),
        .exp_o_in        (exp_o),
        .exp_v_in        (exp_v),
        .last_in         (last_in),
        .issue_in        (issue_in),
        .o_star_prev_out (o_star_prev_out),
        .o_star_prev_vld (o_star_prev_vld),
        .vld_out         (vld_out),
        .rdy_in          (rdy_in),
        .o_star_out      (o_star_out),
        .key_cnt_out     (key_cnt_out),
        .err_out         (err_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DIM; i++) begin
            m_acc[i] = 0;
            m_out[i] = 0;
        end
        m_cnt = 0; m_cnt_out = 0;
        m_inflight = 1'b0; m_err = 1'b0; m_drain = 1'b0;
    endtask

    // One clock of the specified behaviour, using the inputs present at the edge.
    task automatic model_clock();
        bit     inf0, drn0;
        longint a, b, s;
        inf0 = m_inflight;
        drn0 = m_drain;
        if (!drn0) begin
            if (vld_in) begin
                if (!inf0) m_err = 1'b1;
                for (int i = 0; i < DIM; i++) begin
                    a = $signed(exp_o[i]);
                    b = $signed(exp_v[i]);
                    s = a + b;
                    if (s > QMAX) begin s = QMAX; m_err = 1'b1; end
                    if (s < QMIN) begin s = QMIN; m_err = 1'b1; end
                    m_acc[i] = s;
                end
                if (m_cnt >= MAX_KEYS) m_err = 1'b1;
                else m_cnt = m_cnt + 1;
                m_inflight = 1'b0;
                if (last_in) begin
                    for (int i = 0; i < DIM; i++) m_out[i] = m_acc[i];
                    m_cnt_out = m_cnt;
                    m_drain   = 1'b1;
                end
            end
        end else if (rdy_in) begin
            for (int i = 0; i < DIM; i++) m_acc[i] = 0;
            m_cnt = 0;
            m_inflight = 1'b0;
            m_drain = 1'b0;
        end
        if (issue_in) begin
            if (inf0 || drn0) m_err = 1'b1;
            else m_inflight = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " rdy_out"}, rdy_out, !m_drain);
        chk({tag, " o_star_prev_vld"}, o_star_prev_vld, (!m_drain && !m_inflight));
        chk({tag, " vld_out"}, vld_out, m_drain);
        chk({tag, " err_out"}, err_out, m_err);
        chk({tag, " key_cnt_out"}, key_cnt_out, m_cnt_out);
        for (int i = 0; i < DIM; i++) begin
            chk($sformatf("%s o_star_out[%0d]", tag, i), $signed(o_star_out[i]), m_out[i]);
            chk($sformatf("%s o_star_prev_out[%0d]", tag, i), $signed(o_star_prev_out[i]), m_acc[i]);
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_clock();
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset asserted between edges; outputs must return at once.
    task automatic do_reset(input string tag);
        #1;
        rst = 1'b0;
        vld_in = 1'b0; issue_in = 1'b0; last_in = 1'b0; rdy_in = 1'b0;
        exp_o = '0; exp_v = '0;
        #1;
        model_reset();
        check_all({tag, " async"});
        @(posedge clk);
        #1;
        check_all({tag, " held"});
        rst = 1'b1;
    endtask

    task automatic send_key(input string tag, input star_vector_t ov, input star_vector_t vv, input logic lst);
        issue_in = 1'b1;
        cycle({tag, " issue"});
        issue_in = 1'b0;
        vld_in = 1'b1; exp_o = ov; exp_v = vv; last_in = lst;
        cycle({tag, " accept"});
        vld_in = 1'b0; last_in = 1'b0; exp_o = '0; exp_v = '0;
    endtask

    task automatic drain(input string tag, input int stall);
        rdy_in = 1'b0;
        for (int i = 0; i < stall; i++) cycle({tag, " stall"});
        rdy_in = 1'b1;
        cycle({tag, " drain"});
        rdy_in = 1'b0;
        cycle({tag, " post"});
    endtask

    function automatic star_vector_t feedback();
        star_vector_t f;
        for (int i = 0; i < DIM; i++) f[i] = 27'(m_acc[i] >>> 1);
        return f;
    endfunction

    initial begin
        star_vector_t ov, vv;
        int nk;
        model_reset();
        do_reset("reset");

        // 1: single key.
        ov = '0; vv = '0; vv[1] = 27'd32768;
        send_key("t1", ov, vv, 1'b1);
        chk("t1 lane1", $signed(o_star_out[1]), 64'sd32768);
        chk("t1 cnt", key_cnt_out, 64'sd1);
        drain("t1", 0);

        // 2: three keys with halved feedback.
        for (int k = 0; k < 3; k++) begin
            vv = '0; vv[1] = 27'd131072;
            send_key("t2", feedback(), vv, (k == 2));
        end
        chk("t2 lane1", $signed(o_star_out[1]), 64'sd229376);
        chk("t2 cnt", key_cnt_out, 64'sd3);

        // 4: backpressure in DRAIN.
        drain("t4", 5);

        // 5a: double issue.
        issue_in = 1'b1;
        cycle("t5 issue1");
        cycle("t5 issue2");
        issue_in = 1'b0;
        chk("t5 double err", err_out, 64'sd1);
        vld_in = 1'b1; last_in = 1'b1; exp_v[2] = 27'd100;
        cycle("t5 accept");
        vld_in = 1'b0; last_in = 1'b0; exp_v = '0;
        drain("t5", 1);
        do_reset("t5 rst");

        // 5b: unsolicited result.
        vld_in = 1'b1; exp_o[3] = 27'd5; exp_v[3] = 27'd7;
        cycle("t5 unsol");
        vld_in = 1'b0; exp_o = '0; exp_v = '0;
        chk("t5 unsol err", err_out, 64'sd1);
        chk("t5 unsol acc", $signed(o_star_prev_out[3]), 64'sd12);
        do_reset("t5b rst");

        // 6: reset mid-row, then a fresh single-key row.
        for (int k = 0; k < 2; k++) begin
            vv = '0; vv[0] = 27'd1000;
            send_key("t6", feedback(), vv, 1'b0);
        end
        do_reset("t6 rst");
        vv = '0; vv[4] = 27'd4096;
        send_key("t6 fresh", '0, vv, 1'b1);
        chk("t6 cnt", key_cnt_out, 64'sd1);
        chk("t6 err", err_out, 64'sd0);
        drain("t6", 0);

        // 3: saturation, positive and negative.
        ov = '0; vv = '0;
        ov[0] = 27'h3FFFFFF; vv[0] = 27'h3FFFFFF;
        ov[4] = 27'h4000000; vv[4] = 27'h4000000;
        send_key("t3", ov, vv, 1'b1);
        chk("t3 pos", $signed(o_star_out[0]), 64'sd67108863);
        chk("t3 neg", $signed(o_star_out[4]), -64'sd67108864);
        chk("t3 err", err_out, 64'sd1);
        drain("t3", 2);
        do_reset("t3 rst");

        // Key counter saturation at MAX_KEYS.
        for (int k = 0; k <= MAX_KEYS; k++) begin
            vv = '0; vv[2] = 27'd1;
            send_key("cnt", feedback(), vv, (k == MAX_KEYS));
        end
        chk("cnt sat", key_cnt_out, 64'(MAX_KEYS));
        chk("cnt err", err_out, 64'sd1);
        drain("cnt", 1);
        do_reset("cnt rst");

        // Randomized rows.
        for (int r = 0; r < 20; r++) begin
            nk = $urandom_range(1, 4);
            for (int k = 0; k < nk; k++) begin
                ov = feedback();
                for (int i = 0; i < DIM; i++) begin
                    if ($urandom_range(0, 3) == 0) vv[i] = 27'($urandom);
                    else vv[i] = 27'(int'($urandom_range(0, 262143)) - 131072);
                end
                if ($urandom_range(0, 4) == 0) ov = 27'($urandom);
                send_key("rnd", ov, vv, (k == nk - 1));
                if ($urandom_range(0, 2) == 0) cycle("rnd idle");
            end
            drain("rnd", $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
